alu_ctl_muldiv: RTL

Next-generation EX-stage ALU control for the MIPS pipeline.
- Registers the ALUOp/instruction decode into a 4-bit ALU control code with 1-cycle latency.
- Adds a parametrised iterative HI/LO multiply/divide sequencer (MULT, MULTU, DIV, DIVU, MTHI, MTLO, MFHI, MFLO).
- Drives a pipeline stall while a HI/LO-class instruction depends on a running operation.

---
 rtl/alu_ctl_muldiv_if.sv | 27 ++
 rtl/alu_ctl_muldiv.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_ctl_muldiv_if.sv
// EX-stage bus of the ALU control / HI-LO multiply-divide block.
// master drives the instruction and operands; slave returns the control code, stall and HI/LO.
interface alu_ctl_muldiv_if #(
   parameter int DATA_W = 32
);
   logic              valid_in;
   logic [31:0]       instruccion;
   logic [1:0]        ALUOp;
   logic [DATA_W-1:0] op_a;
   logic [DATA_W-1:0] op_b;
   logic [3:0]        ALUctl;
   logic              stall;
   logic              md_busy;
   logic              md_done;
   logic [DATA_W-1:0] hi;
   logic [DATA_W-1:0] lo;

   modport master (
      output valid_in, instruccion, ALUOp, op_a, op_b,
      input  ALUctl, stall, md_busy, md_done, hi, lo
   );

   modport slave (
      input  valid_in, instruccion, ALUOp, op_a, op_b,
      output ALUctl, stall, md_busy, md_done, hi, lo
   );
endinterface

// File: rtl/alu_ctl_muldiv.sv
// EX-stage ALU control decode plus an iterative HI/LO multiply/divide sequencer.
// Optional macro MD_EARLY_OUT_EN: multiplies finish once the remaining multiplier bits are zero.
module alu_ctl_muldiv #(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 6
) (
   input logic             clk,
   input logic             reset_n,
   alu_ctl_muldiv_if.slave bus
);
   localparam int PW = 2 * DATA_W;

   localparam logic [5:0] F_MULT  = 6'b011000;
   localparam logic [5:0] F_MULTU = 6'b011001;
   localparam logic [5:0] F_DIV   = 6'b011010;
   localparam logic [5:0] F_DIVU  = 6'b011011;
   localparam logic [5:0] F_MFHI  = 6'b010000;
   localparam logic [5:0] F_MTHI  = 6'b010001;
   localparam logic [5:0] F_MFLO  = 6'b010010;
   localparam logic [5:0] F_MTLO  = 6'b010011;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ITER = 2'd1,
      FIX  = 2'd2
   } md_state_t;

   function automatic logic [3:0] decode_alu(input logic [1:0] alu_op,
                                             input logic [5:0] opcode,
                                             input logic [5:0] funct);
      logic [3:0] code;
      code = 4'b0000;
      if (alu_op[0]) begin
         code = 4'b0110;
      end else if (alu_op == 2'b00) begin
         code = 4'b0010;
      end else if (opcode == 6'b000000) begin
         case (funct)
            6'b100000: code = 4'b0010;
            6'b100010: code = 4'b0110;
            6'b100100: code = 4'b0000;
            6'b100101: code = 4'b0001;
            6'b100111: code = 4'b0011;
            6'b100110: code = 4'b1000;
            6'b101010: code = 4'b0111;
            6'b000000: code = 4'b0100;
            6'b000100: code = 4'b0100;
            6'b000010: code = 4'b0101;
            6'b000110: code = 4'b1001;
            6'b000011: code = 4'b1010;
            6'b000111: code = 4'b1010;
            default:   code = 4'b0000;
         endcase
      end else begin
         case (opcode)
            6'b001000: code = 4'b0010;
            6'b001100: code = 4'b0000;
            6'b001101: code = 4'b0001;
            6'b001110: code = 4'b1000;
            6'b001010: code = 4'b0111;
            6'b001111: code = 4'b1111;
            default:   code = 4'b0000;
         endcase
      end
      return code;
   endfunction

   md_state_t         state_r;
   logic [CNT_W-1:0]  cnt_r;
   logic [PW-1:0]     acc_r;       // product accumulator; low half is the divide remainder
   logic [PW-1:0]     mcand_r;     // shifted multiplicand; low half is the divisor
   logic [DATA_W-1:0] mplier_r;    // multiplier bits, or dividend shifting into quotient
   logic              is_div_r;
   logic              neg_q_r;
   logic              neg_r_r;
   logic              div_zero_r;
   logic              busy_r;
   logic              done_r;
   logic [DATA_W-1:0] hi_r;
   logic [DATA_W-1:0] lo_r;
   logic [3:0]        alu_ctl_r;

   logic [5:0]        opcode_s;
   logic [5:0]        funct_s;
   logic              hilo_class_s;
   logic              is_mul_s;
   logic              is_div_s;
   logic              is_signed_s;
   logic              is_mthi_s;
   logic              is_mtlo_s;
   logic              stall_s;
   logic              accept_s;
   logic              neg_a_s;
   logic              neg_b_s;
   logic [DATA_W-1:0] abs_a_s;
   logic [DATA_W-1:0] abs_b_s;
   logic [PW-1:0]     mul_acc_s;
   logic [DATA_W:0]   rem_sh_s;
   logic [DATA_W:0]   diff_s;
   logic              mul_last_s;
   logic              last_step_s;
   logic [PW-1:0]     prod_fix_s;
   logic [DATA_W-1:0] quo_fix_s;
   logic [DATA_W-1:0] rem_fix_s;
   logic              unused_s;

   assign opcode_s = bus.instruccion[31:26];
   assign funct_s  = bus.instruccion[5:0];
   assign unused_s = ^bus.instruccion[25:6];

   // Classify HI/LO-class instructions and derive operand magnitudes.
   always_comb begin
      hilo_class_s = 1'b0;
      is_mul_s     = 1'b0;
      is_div_s     = 1'b0;
      is_signed_s  = 1'b0;
      is_mthi_s    = 1'b0;
      is_mtlo_s    = 1'b0;
      if (opcode_s == 6'b000000) begin
         case (funct_s)
            F_MULT:  begin hilo_class_s = 1'b1; is_mul_s = 1'b1; is_signed_s = 1'b1; end
            F_MULTU: begin hilo_class_s = 1'b1; is_mul_s = 1'b1; end
            F_DIV:   begin hilo_class_s = 1'b1; is_div_s = 1'b1; is_signed_s = 1'b1; end
            F_DIVU:  begin hilo_class_s = 1'b1; is_div_s = 1'b1; end
            F_MTHI:  begin hilo_class_s = 1'b1; is_mthi_s = 1'b1; end
            F_MTLO:  begin hilo_class_s = 1'b1; is_mtlo_s = 1'b1; end
            F_MFHI:  hilo_class_s = 1'b1;
            F_MFLO:  hilo_class_s = 1'b1;
            default: hilo_class_s = 1'b0;
         endcase
      end else begin
         hilo_class_s = 1'b0;
      end
      neg_a_s = is_signed_s & bus.op_a[DATA_W-1];
      neg_b_s = is_signed_s & bus.op_b[DATA_W-1];
      if (neg_a_s) abs_a_s = ~bus.op_a + DATA_W'(1);
      else         abs_a_s = bus.op_a;
      if (neg_b_s) abs_b_s = ~bus.op_b + DATA_W'(1);
      else         abs_b_s = bus.op_b;
   end

   assign stall_s  = bus.valid_in & hilo_class_s & busy_r;
   assign accept_s = bus.valid_in & ~stall_s;

   // One radix-2 step and the final sign correction.
   always_comb begin
      if (mplier_r[0]) mul_acc_s = acc_r + mcand_r;
      else             mul_acc_s = acc_r;
      rem_sh_s = {acc_r[DATA_W-1:0], mplier_r[DATA_W-1]};
      diff_s   = rem_sh_s - {1'b0, mcand_r[DATA_W-1:0]};
`ifdef MD_EARLY_OUT_EN
      mul_last_s = ~is_div_r & (mplier_r[DATA_W-1:1] == {(DATA_W-1){1'b0}});
`else
      mul_last_s = 1'b0;
`endif
      last_step_s = (cnt_r == CNT_W'(DATA_W - 1)) | mul_last_s;
      if (neg_q_r) prod_fix_s = ~acc_r + PW'(1);
      else         prod_fix_s = acc_r;
      if (div_zero_r)   quo_fix_s = {DATA_W{1'b1}};
      else if (neg_q_r) quo_fix_s = ~mplier_r + DATA_W'(1);
      else              quo_fix_s = mplier_r;
      if (neg_r_r) rem_fix_s = ~acc_r[DATA_W-1:0] + DATA_W'(1);
      else         rem_fix_s = acc_r[DATA_W-1:0];
   end

   // ALU control code register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         alu_ctl_r <= 4'b0000;
      end else if (accept_s) begin
         alu_ctl_r <= decode_alu(bus.ALUOp, opcode_s, funct_s);
      end else begin
         alu_ctl_r <= alu_ctl_r;
      end
   end

   // Multiply/divide sequencer FSM with HI/LO and status registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r    <= IDLE;
         cnt_r      <= {CNT_W{1'b0}};
         acc_r      <= {PW{1'b0}};
         mcand_r    <= {PW{1'b0}};
         mplier_r   <= {DATA_W{1'b0}};
         is_div_r   <= 1'b0;
         neg_q_r    <= 1'b0;
         neg_r_r    <= 1'b0;
         div_zero_r <= 1'b0;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
         hi_r       <= {DATA_W{1'b0}};
         lo_r       <= {DATA_W{1'b0}};
      end else begin
         done_r <= 1'b0;
         case (state_r)
            IDLE: begin
               if (accept_s & (is_mul_s | is_div_s)) begin
                  state_r    <= ITER;
                  busy_r     <= 1'b1;
                  cnt_r      <= {CNT_W{1'b0}};
                  acc_r      <= {PW{1'b0}};
                  is_div_r   <= is_div_s;
                  neg_q_r    <= neg_a_s ^ neg_b_s;
                  neg_r_r    <= neg_a_s;
                  div_zero_r <= is_div_s & (bus.op_b == {DATA_W{1'b0}});
                  if (is_div_s) begin
                     mcand_r  <= {{DATA_W{1'b0}}, abs_b_s};
                     mplier_r <= abs_a_s;
                  end else begin
                     mcand_r  <= {{DATA_W{1'b0}}, abs_a_s};
                     mplier_r <= abs_b_s;
                  end
               end else if (accept_s & is_mthi_s) begin
                  hi_r <= bus.op_a;
               end else if (accept_s & is_mtlo_s) begin
                  lo_r <= bus.op_a;
               end else begin
                  state_r <= IDLE;
               end
            end
            ITER: begin
               cnt_r <= cnt_r + CNT_W'(1);
               if (is_div_r) begin
                  if (!diff_s[DATA_W]) begin
                     acc_r    <= {{DATA_W{1'b0}}, diff_s[DATA_W-1:0]};
                     mplier_r <= {mplier_r[DATA_W-2:0], 1'b1};
                  end else begin
                     acc_r    <= {{DATA_W{1'b0}}, rem_sh_s[DATA_W-1:0]};
                     mplier_r <= {mplier_r[DATA_W-2:0], 1'b0};
                  end
               end else begin
                  acc_r    <= mul_acc_s;
                  mcand_r  <= mcand_r << 1;
                  mplier_r <= mplier_r >> 1;
               end
               if (last_step_s) state_r <= FIX;
               else             state_r <= ITER;
            end
            FIX: begin
               if (is_div_r) begin
                  hi_r <= rem_fix_s;
                  lo_r <= quo_fix_s;
               end else begin
                  hi_r <= prod_fix_s[PW-1:DATA_W];
                  lo_r <= prod_fix_s[DATA_W-1:0];
               end
               done_r  <= 1'b1;
               busy_r  <= 1'b0;
               cnt_r   <= {CNT_W{1'b0}};
               state_r <= IDLE;
            end
            default: begin
               state_r <= IDLE;
               busy_r  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.ALUctl  = alu_ctl_r;
   assign bus.stall   = stall_s;
   assign bus.md_busy = busy_r;
   assign bus.md_done = done_r;
   assign bus.hi      = hi_r;
   assign bus.lo      = lo_r;
endmodule
